// File: rtl/mips_isa_pkg.sv
//------------------------------------------------------------------------------
// Module  : mips_isa_pkg
// Brief   : Shared MIPS op/func codes, loader mnemonics and encoder states.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mips_isa_pkg;

    // Same op/func values the single-cycle controller decodes
    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_ori   = 6'b001101;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_lui   = 6'b001111;
    localparam logic [5:0] c_op_jal   = 6'b000011;

    localparam logic [5:0] c_fn_addu  = 6'b100001;
    localparam logic [5:0] c_fn_subu  = 6'b100011;
    localparam logic [5:0] c_fn_jr    = 6'b001000;

    localparam logic [31:0] c_base_addr_default = 32'h0000_3000;

    typedef enum logic [3:0] {
        MN_NOP  = 4'd0,
        MN_ADDU = 4'd1,
        MN_SUBU = 4'd2,
        MN_ORI  = 4'd3,
        MN_LW   = 4'd4,
        MN_SW   = 4'd5,
        MN_BEQ  = 4'd6,
        MN_LUI  = 4'd7,
        MN_JAL  = 4'd8,
        MN_JR   = 4'd9
    } mnem_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_FULL = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mips_word_pack.sv
//------------------------------------------------------------------------------
// Module  : mips_word_pack
// Brief   : Combinational mnemonic + register fields -> 32-bit MIPS word.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mips_word_pack
    import mips_isa_pkg::*;
(
    input  logic [3:0]  i_mnem,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [25:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_illegal
);

    always_comb begin
        o_word    = 32'h0000_0000;
        o_illegal = 1'b0;
        case (i_mnem)
            MN_NOP:  o_word = 32'h0000_0000;
            MN_ADDU: o_word = {c_op_rtype, i_rs, i_rt, i_rd, 5'b00000, c_fn_addu};
            MN_SUBU: o_word = {c_op_rtype, i_rs, i_rt, i_rd, 5'b00000, c_fn_subu};
            MN_ORI:  o_word = {c_op_ori, i_rs, i_rt, i_imm[15:0]};
            MN_LW:   o_word = {c_op_lw,  i_rs, i_rt, i_imm[15:0]};
            MN_SW:   o_word = {c_op_sw,  i_rs, i_rt, i_imm[15:0]};
            MN_BEQ:  o_word = {c_op_beq, i_rs, i_rt, i_imm[15:0]};
            // rs is architecturally zero for LUI regardless of the request
            MN_LUI:  o_word = {c_op_lui, 5'b00000, i_rt, i_imm[15:0]};
            MN_JAL:  o_word = {c_op_jal, i_imm};
            MN_JR:   o_word = {c_op_rtype, i_rs, 15'b0, c_fn_jr};
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mips_instr_encoder.sv
//------------------------------------------------------------------------------
// Module  : mips_instr_encoder
// Brief   : Symbolic-request to instruction-memory program loader.
//           Optional running XOR checksum output: MIPS_ENC_CHECKSUM_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mips_instr_encoder
    import mips_isa_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = c_base_addr_default
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_mnem,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [25:0]       in_imm,
    output logic              im_we,
    output logic [31:0]       im_addr,
    output logic [31:0]       im_wdata,
    input  logic              im_ack,
    output logic [ADDR_W:0]   count,
`ifdef MIPS_ENC_CHECKSUM_EN
    output logic [31:0]       checksum,
`endif
    output logic              full,
    output logic              err_illegal
);

    localparam logic [ADDR_W-1:0] c_last_index = '1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_index;
    logic [ADDR_W:0]    r_count;
    logic               r_we;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic               r_full;
    logic               r_err;

    logic [31:0]        w_word;
    logic               w_illegal;
    logic               w_accept;
    logic               w_start_ok;
    logic               w_wr_done;
    logic               w_last;
    logic [31:0]        w_addr_nxt;

    mips_word_pack u_pack (
        .i_mnem    (in_mnem),
        .i_rs      (in_rs),
        .i_rt      (in_rt),
        .i_rd      (in_rd),
        .i_imm     (in_imm),
        .o_word    (w_word),
        .o_illegal (w_illegal)
    );

    // A start pulse masks the handshake so a same-cycle request is never taken
    assign in_ready   = (r_state == ST_IDLE) && !start;
    assign w_accept   = in_valid && in_ready;
    assign w_start_ok = start && (r_state != ST_WR);
    assign w_wr_done  = (r_state == ST_WR) && im_ack;
    assign w_last     = (r_index == c_last_index);
    assign w_addr_nxt = BASE_ADDR + {{(30-ADDR_W){1'b0}}, r_index, 2'b00};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !w_illegal) begin
                    w_state_nxt = ST_WR;
                end
            end
            ST_WR: begin
                if (im_ack) begin
                    w_state_nxt = w_last ? ST_FULL : ST_IDLE;
                end
            end
            ST_FULL: begin
                if (start) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // start, accept and write-completion are mutually exclusive by state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_index <= '0;
            r_count <= '0;
            r_we    <= 1'b0;
            r_addr  <= BASE_ADDR;
            r_wdata <= 32'h0000_0000;
            r_full  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_index <= '0;
                r_count <= '0;
                r_full  <= 1'b0;
                r_err   <= 1'b0;
            end
            if (w_accept) begin
                if (w_illegal) begin
                    r_err <= 1'b1;
                end else begin
                    r_we    <= 1'b1;
                    r_addr  <= w_addr_nxt;
                    r_wdata <= w_word;
                end
            end
            if (w_wr_done) begin
                r_we    <= 1'b0;
                r_count <= r_count + 1'b1;
                if (w_last) begin
                    r_full <= 1'b1;
                end else begin
                    r_index <= r_index + 1'b1;
                end
            end
        end
    end

`ifdef MIPS_ENC_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_checksum <= 32'h0000_0000;
        end else if (w_start_ok) begin
            r_checksum <= 32'h0000_0000;
        end else if (w_wr_done) begin
            r_checksum <= r_checksum ^ r_wdata;
        end
    end

    assign checksum = r_checksum;
`endif

    assign im_we       = r_we;
    assign im_addr     = r_addr;
    assign im_wdata    = r_wdata;
    assign count       = r_count;
    assign full        = r_full;
    assign err_illegal = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mips_instr_encoder.sv
//------------------------------------------------------------------------------
// Module  : tb_mips_instr_encoder
// Brief   : Self-checking bench for mips_instr_encoder (ADDR_W=2, 4-word IM).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mips_instr_encoder;

    localparam int          c_addr_w = 2;
    localparam int          c_depth  = 4;
    localparam logic [31:0] c_base   = 32'h0000_3000;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_mnem;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [25:0]       in_imm;
    logic              im_we;
    logic [31:0]       im_addr;
    logic [31:0]       im_wdata;
    logic              im_ack;
    logic [c_addr_w:0] count;
    logic              full;
    logic              err_illegal;
`ifdef MIPS_ENC_CHECKSUM_EN
    logic [31:0]       checksum;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mips_instr_encoder #(
        .ADDR_W    (c_addr_w),
        .BASE_ADDR (c_base)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_mnem     (in_mnem),
        .in_rs       (in_rs),
        .in_rt       (in_rt),
        .in_rd       (in_rd),
        .in_imm      (in_imm),
        .im_we       (im_we),
        .im_addr     (im_addr),
        .im_wdata    (im_wdata),
        .im_ack      (im_ack),
        .count       (count),
`ifdef MIPS_ENC_CHECKSUM_EN
        .checksum    (checksum),
`endif
        .full        (full),
        .err_illegal (err_illegal)
    );

    typedef struct {
        logic [3:0]  mnem;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [25:0] imm;
        logic [31:0] word;
        bit          ill;
        string       name;
    } vec_t;

    vec_t vecs[12];

    // Reference encoding built from field weights rather than bit concatenation
    function automatic logic [31:0] ref_word(input int m, input int rs, input int rt,
                                             input int rd, input int imm, output bit ill);
        longint v;
        longint f26;
        longint i16;
        f26 = 64'd67108864;
        i16 = longint'(imm) % 65536;
        ill = 1'b0;
        v   = 0;
        case (m)
            0: v = 0;
            1: v = rs * 64'd2097152 + rt * 64'd65536 + rd * 64'd2048 + 33;
            2: v = rs * 64'd2097152 + rt * 64'd65536 + rd * 64'd2048 + 35;
            3: v = 13 * f26 + rs * 64'd2097152 + rt * 64'd65536 + i16;
            4: v = 35 * f26 + rs * 64'd2097152 + rt * 64'd65536 + i16;
            5: v = 43 * f26 + rs * 64'd2097152 + rt * 64'd65536 + i16;
            6: v = 4  * f26 + rs * 64'd2097152 + rt * 64'd65536 + i16;
            7: v = 15 * f26 + rt * 64'd65536 + i16;
            8: v = 3  * f26 + (longint'(imm) % f26);
            9: v = rs * 64'd2097152 + 8;
            default: ill = 1'b1;
        endcase
        return v[31:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        #1;
        chk("ready_masked_by_start", {31'b0, in_ready}, 32'h0);
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [3:0] m, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [25:0] imm);
        in_valid = 1'b1;
        in_mnem  = m;
        in_rs    = rs;
        in_rt    = rt;
        in_rd    = rd;
        in_imm   = imm;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wr(input string nm, input logic [3:0] m, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic [25:0] imm,
                      input logic [31:0] exp_word, input logic [31:0] exp_addr, input int delay);
        send(m, rs, rt, rd, imm);
        chk({nm, "_we"},    {31'b0, im_we}, 32'h1);
        chk({nm, "_addr"},  im_addr, exp_addr);
        chk({nm, "_word"},  im_wdata, exp_word);
        chk({nm, "_ready"}, {31'b0, in_ready}, 32'h0);
        for (int d = 0; d < delay; d++) begin
            tick();
            chk({nm, "_stall_we"},    {31'b0, im_we}, 32'h1);
            chk({nm, "_stall_word"},  im_wdata, exp_word);
            chk({nm, "_stall_addr"},  im_addr, exp_addr);
            chk({nm, "_stall_ready"}, {31'b0, in_ready}, 32'h0);
        end
        im_ack = 1'b1;
        tick();
        im_ack = 1'b0;
        chk({nm, "_we_drop"}, {31'b0, im_we}, 32'h0);
    endtask

    int          m_index;
    int          m_count;
    bit          m_full;
    bit          m_err;
    logic [31:0] m_cks;

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_mnem  = 4'd0;
        in_rs    = 5'd0;
        in_rt    = 5'd0;
        in_rd    = 5'd0;
        in_imm   = 26'd0;
        im_ack   = 1'b0;

        vecs[0]  = '{4'd1,  5'd1,  5'd2, 5'd3,  26'h0000000, 32'h00221821, 1'b0, "addu"};
        vecs[1]  = '{4'd2,  5'd5,  5'd6, 5'd7,  26'h0000000, 32'h00A63823, 1'b0, "subu"};
        vecs[2]  = '{4'd3,  5'd0,  5'd1, 5'd9,  26'h3FF1234, 32'h34011234, 1'b0, "ori"};
        vecs[3]  = '{4'd4,  5'd0,  5'd2, 5'd0,  26'h0000004, 32'h8C020004, 1'b0, "lw"};
        vecs[4]  = '{4'd5,  5'd29, 5'd8, 5'd0,  26'h000FFFC, 32'hAFA8FFFC, 1'b0, "sw"};
        vecs[5]  = '{4'd6,  5'd4,  5'd5, 5'd0,  26'h0000003, 32'h10850003, 1'b0, "beq"};
        vecs[6]  = '{4'd7,  5'd7,  5'd9, 5'd0,  26'h000ABCD, 32'h3C09ABCD, 1'b0, "lui"};
        vecs[7]  = '{4'd8,  5'd0,  5'd0, 5'd0,  26'h0000C03, 32'h0C000C03, 1'b0, "jal"};
        vecs[8]  = '{4'd9,  5'd31, 5'd4, 5'd6,  26'h0001234, 32'h03E00008, 1'b0, "jr"};
        vecs[9]  = '{4'd0,  5'd31, 5'd3, 5'd17, 26'h3FFFFFF, 32'h00000000, 1'b0, "nop"};
        vecs[10] = '{4'd12, 5'd1,  5'd2, 5'd3,  26'h0000000, 32'h00000000, 1'b1, "ill12"};
        vecs[11] = '{4'd15, 5'd1,  5'd2, 5'd3,  26'h0000000, 32'h00000000, 1'b1, "ill15"};

        // Reset state while reset is held low
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, in_ready}, 32'h1);
        chk("rst_we",    {31'b0, im_we}, 32'h0);
        chk("rst_addr",  im_addr, c_base);
        chk("rst_wdata", im_wdata, 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_full",  {31'b0, full}, 32'h0);
        chk("rst_err",   {31'b0, err_illegal}, 32'h0);
        reset = 1'b1;
        tick();

        // Single-request table, each from a freshly started loader
        for (int i = 0; i < 12; i++) begin
            pulse_start();
            chk({vecs[i].name, "_cleared_err"}, {31'b0, err_illegal}, 32'h0);
            chk({vecs[i].name, "_cleared_cnt"}, 32'(count), 32'h0);
            if (vecs[i].ill) begin
                send(vecs[i].mnem, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm);
                chk({vecs[i].name, "_err"},   {31'b0, err_illegal}, 32'h1);
                chk({vecs[i].name, "_no_we"}, {31'b0, im_we}, 32'h0);
                chk({vecs[i].name, "_count"}, 32'(count), 32'h0);
                chk({vecs[i].name, "_ready"}, {31'b0, in_ready}, 32'h1);
            end else begin
                wr(vecs[i].name, vecs[i].mnem, vecs[i].rs, vecs[i].rt, vecs[i].rd,
                   vecs[i].imm, vecs[i].word, c_base, 0);
                chk({vecs[i].name, "_count"}, 32'(count), 32'h1);
            end
        end
        pulse_start();
        chk("start_clears_err", {31'b0, err_illegal}, 32'h0);

        // ORI then LW with a 3-cycle acknowledge stall each
        wr("ori_stall", 4'd3, 5'd0, 5'd1, 5'd0, 26'h1234, 32'h34011234, 32'h3000, 3);
        wr("lw_stall",  4'd4, 5'd0, 5'd2, 5'd0, 26'h0004, 32'h8C020004, 32'h3004, 3);
        chk("stall_count", 32'(count), 32'h2);

        // start during WR is ignored so the pending write completes
        send(4'd1, 5'd1, 5'd2, 5'd3, 26'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("wr_start_ignored_we",   {31'b0, im_we}, 32'h1);
        chk("wr_start_ignored_addr", im_addr, 32'h3008);
        im_ack = 1'b1;
        tick();
        im_ack = 1'b0;
        chk("wr_start_ignored_count", 32'(count), 32'h3);

        // Fill the last slot, then no wrap-around
        wr("fill4", 4'd0, 5'd0, 5'd0, 5'd0, 26'd0, 32'h0, 32'h300C, 1);
        chk("full_flag",  {31'b0, full}, 32'h1);
        chk("full_count", 32'(count), 32'h4);
        chk("full_ready", {31'b0, in_ready}, 32'h0);
        in_valid = 1'b1;
        in_mnem  = 4'd1;
        repeat (3) tick();
        chk("full_no_we",  {31'b0, im_we}, 32'h0);
        chk("full_count2", 32'(count), 32'h4);
        // start with a request pending: the request must not be taken this cycle
        pulse_start();
        in_valid = 1'b0;
        chk("after_start_no_we", {31'b0, im_we}, 32'h0);
        chk("after_start_full",  {31'b0, full}, 32'h0);
        chk("after_start_count", 32'(count), 32'h0);
        wr("restart", 4'd3, 5'd0, 5'd1, 5'd0, 26'h1234, 32'h34011234, 32'h3000, 0);

`ifdef MIPS_ENC_CHECKSUM_EN
        pulse_start();
        chk("cks_cleared", checksum, 32'h0);
        wr("cks_a", 4'd1, 5'd1, 5'd2, 5'd3, 26'd0,     32'h00221821, 32'h3000, 0);
        wr("cks_b", 4'd3, 5'd0, 5'd1, 5'd0, 26'h1234,  32'h34011234, 32'h3004, 2);
        chk("cks_value", checksum, 32'h34230A15);
`endif

        // Randomised requests against the reference model
        pulse_start();
        m_index = 0;
        m_count = 0;
        m_full  = 1'b0;
        m_err   = 1'b0;
        m_cks   = 32'h0;
        for (int it = 0; it < 200; it++) begin
            if (m_full) begin
                chk("rnd_full",  {31'b0, full}, 32'h1);
                chk("rnd_ready", {31'b0, in_ready}, 32'h0);
                send(4'($urandom_range(0, 9)), 5'($urandom), 5'($urandom), 5'($urandom), 26'($urandom));
                chk("rnd_full_no_we", {31'b0, im_we}, 32'h0);
                chk("rnd_full_count", 32'(count), 32'(c_depth));
                pulse_start();
                m_index = 0; m_count = 0; m_full = 1'b0; m_err = 1'b0; m_cks = 32'h0;
                chk("rnd_restart_count", 32'(count), 32'h0);
            end else if ($urandom_range(0, 7) == 0) begin
                pulse_start();
                m_index = 0; m_count = 0; m_err = 1'b0; m_cks = 32'h0;
                chk("rnd_start_count", 32'(count), 32'h0);
                chk("rnd_start_err",   {31'b0, err_illegal}, 32'h0);
            end else begin
                int          m, rs, rt, rd, imm, dly;
                bit          ill;
                logic [31:0] w;
                m   = $urandom_range(0, 15);
                rs  = $urandom_range(0, 31);
                rt  = $urandom_range(0, 31);
                rd  = $urandom_range(0, 31);
                imm = $urandom_range(0, 67108863);
                dly = $urandom_range(0, 3);
                w   = ref_word(m, rs, rt, rd, imm, ill);
                if (ill) begin
                    send(4'(m), 5'(rs), 5'(rt), 5'(rd), 26'(imm));
                    m_err = 1'b1;
                    chk("rnd_ill_no_we", {31'b0, im_we}, 32'h0);
                end else begin
                    wr("rnd", 4'(m), 5'(rs), 5'(rt), 5'(rd), 26'(imm), w,
                       c_base + 32'(4 * m_index), dly);
                    m_count++;
                    m_cks = m_cks ^ w;
                    if (m_index == c_depth - 1) m_full = 1'b1;
                    else                        m_index++;
                end
                chk("rnd_count", 32'(count), 32'(m_count));
                chk("rnd_fullf", {31'b0, full}, {31'b0, m_full});
                chk("rnd_err",   {31'b0, err_illegal}, {31'b0, m_err});
`ifdef MIPS_ENC_CHECKSUM_EN
                chk("rnd_cks", checksum, m_cks);
`endif
            end
        end

        // Reset asserted mid-write drops everything without waiting for a clock
        if (m_full) pulse_start();
        else        pulse_start();
        send(4'd13, 5'd0, 5'd0, 5'd0, 26'd0);
        send(4'd1, 5'd1, 5'd2, 5'd3, 26'd0);
        chk("abort_pre_we", {31'b0, im_we}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_we",    {31'b0, im_we}, 32'h0);
        chk("abort_addr",  im_addr, c_base);
        chk("abort_wdata", im_wdata, 32'h0);
        chk("abort_count", 32'(count), 32'h0);
        chk("abort_full",  {31'b0, full}, 32'h0);
        chk("abort_err",   {31'b0, err_illegal}, 32'h0);
        chk("abort_ready", {31'b0, in_ready}, 32'h1);
`ifdef MIPS_ENC_CHECKSUM_EN
        chk("abort_cks", checksum, 32'h0);
`endif
        tick();
        reset = 1'b1;
        tick();
        wr("post_abort", 4'd9, 5'd31, 5'd0, 5'd0, 26'd0, 32'h03E00008, 32'h3000, 0);
        chk("post_abort_count", 32'(count), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
